// File: rtl/ctl_stack_unit.sv
// ctl_stack_unit: per-PE enable (predication) stack plus call/return-address stack for the sequencer.
// Define CTL_STACK_GUARD_EN to enable overflow/underflow/illegal-op faults and the ERR state.
module ctl_stack_unit #(
    parameter int ADDR_W     = 16,
    parameter int CALL_DEPTH = 4,
    parameter int EN_DEPTH   = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            op_valid,
    input  logic [2:0]                      op,
    input  logic                            cond,
    input  logic [ADDR_W-1:0]               call_addr,
    input  logic                            err_clr,
    output logic                            op_ready,
    output logic                            en,
    output logic                            take,
    output logic [ADDR_W-1:0]               ret_addr,
    output logic [$clog2(CALL_DEPTH+1)-1:0] call_cnt,
    output logic [$clog2(EN_DEPTH)-1:0]     en_cnt,
    output logic                            err,
    output logic [1:0]                      err_code
);
    localparam int CW = $clog2(CALL_DEPTH+1);
    localparam int EW = $clog2(EN_DEPTH);
    localparam logic [CW-1:0] CALL_FULL = CW'(CALL_DEPTH);
    localparam logic [EW-1:0] EN_FULL   = EW'(EN_DEPTH-1);
    localparam logic [1:0] E_OVF = 2'd1;
    localparam logic [1:0] E_UNF = 2'd2;
    localparam logic [1:0] E_ILL = 2'd3;

`ifdef CTL_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef enum logic [2:0] {
        OP_NOP, OP_ALLEN, OP_POPEN, OP_PUSHEN, OP_JUMPF, OP_CALL, OP_RET, OP_RSVD
    } op_t;

    logic [EN_DEPTH-1:0] en_stk_q, en_stk_d;
    logic [ADDR_W-1:0]   call_stk_q [CALL_DEPTH];
    logic [ADDR_W-1:0]   call_stk_d [CALL_DEPTH];
    logic [CW-1:0]       call_cnt_q, call_cnt_d;
    logic [EW-1:0]       en_cnt_q, en_cnt_d;
    logic                take_q, take_d;
    logic [ADDR_W-1:0]   ret_addr_q, ret_addr_d;
    logic                accept;
    logic                fault;
    logic [1:0]          fault_code;

    assign accept = op_valid && op_ready;

    // Entry 0 of the call stack is the top; pushes shift toward the bottom and drop the oldest.
    always_comb begin
        en_stk_d   = en_stk_q;
        call_stk_d = call_stk_q;
        call_cnt_d = call_cnt_q;
        en_cnt_d   = en_cnt_q;
        ret_addr_d = ret_addr_q;
        take_d     = 1'b0;
        fault      = 1'b0;
        fault_code = 2'd0;
        if (accept) begin
            case (op_t'(op))
                OP_ALLEN: en_stk_d[0] = 1'b1;
                OP_POPEN: begin
                    if (GUARD && en_cnt_q == '0) begin
                        fault      = 1'b1;
                        fault_code = E_UNF;
                    end else begin
                        en_stk_d = {1'b0, en_stk_q[EN_DEPTH-1:1]};
                        if (en_cnt_q != '0) en_cnt_d = en_cnt_q - 1'b1;
                    end
                end
                OP_PUSHEN: begin
                    if (GUARD && en_cnt_q == EN_FULL) begin
                        fault      = 1'b1;
                        fault_code = E_OVF;
                    end else begin
                        en_stk_d = {en_stk_q[EN_DEPTH-2:0], en_stk_q[0]};
                        if (en_cnt_q != EN_FULL) en_cnt_d = en_cnt_q + 1'b1;
                    end
                end
                OP_JUMPF: begin
                    take_d = ~(en_stk_q[0] & cond);
                    if (!cond) en_stk_d[0] = 1'b0;
                end
                OP_CALL: begin
                    if (en_stk_q[0]) begin
                        if (GUARD && call_cnt_q == CALL_FULL) begin
                            fault      = 1'b1;
                            fault_code = E_OVF;
                        end else begin
                            for (int i = CALL_DEPTH-1; i > 0; i--) call_stk_d[i] = call_stk_q[i-1];
                            call_stk_d[0] = call_addr;
                            if (call_cnt_q != CALL_FULL) call_cnt_d = call_cnt_q + 1'b1;
                            take_d = 1'b1;
                        end
                    end
                end
                OP_RET: begin
                    if (en_stk_q[0]) begin
                        if (GUARD && call_cnt_q == '0) begin
                            fault      = 1'b1;
                            fault_code = E_UNF;
                        end else begin
                            ret_addr_d = (call_cnt_q == '0) ? '0 : call_stk_q[0];
                            for (int i = 0; i < CALL_DEPTH-1; i++) call_stk_d[i] = call_stk_q[i+1];
                            call_stk_d[CALL_DEPTH-1] = '0;
                            if (call_cnt_q != '0) call_cnt_d = call_cnt_q - 1'b1;
                            take_d = 1'b1;
                        end
                    end
                end
                OP_RSVD: begin
                    if (GUARD) begin
                        fault      = 1'b1;
                        fault_code = E_ILL;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_stk_q   <= '1;
            call_cnt_q <= '0;
            en_cnt_q   <= '0;
            take_q     <= 1'b0;
            ret_addr_q <= '0;
            for (int i = 0; i < CALL_DEPTH; i++) call_stk_q[i] <= '0;
        end else begin
            en_stk_q   <= en_stk_d;
            call_stk_q <= call_stk_d;
            call_cnt_q <= call_cnt_d;
            en_cnt_q   <= en_cnt_d;
            take_q     <= take_d;
            ret_addr_q <= ret_addr_d;
        end
    end

    assign en       = en_stk_q[0];
    assign take     = take_q;
    assign ret_addr = ret_addr_q;
    assign call_cnt = call_cnt_q;
    assign en_cnt   = en_cnt_q;

`ifdef CTL_STACK_GUARD_EN
    typedef enum logic {RUN, ERR} state_t;
    state_t     state_q;
    logic [1:0] err_code_q;

    // A clear in ERR wins over a simultaneous op, which op_ready=0 already rejects.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            err_code_q <= 2'd0;
        end else begin
            case (state_q)
                RUN: if (fault) begin
                    state_q    <= ERR;
                    err_code_q <= fault_code;
                end
                ERR: if (err_clr) begin
                    state_q    <= RUN;
                    err_code_q <= 2'd0;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign op_ready = (state_q == RUN);
    assign err      = (state_q == ERR);
    assign err_code = err_code_q;
`else
    logic unused_guard;
    assign unused_guard = &{1'b0, err_clr, fault, fault_code};
    assign op_ready = 1'b1;
    assign err      = 1'b0;
    assign err_code = 2'd0;
`endif

endmodule

// File: tb/tb_ctl_stack_unit.sv
// Directed bench for ctl_stack_unit; guard-mode scenarios run when CTL_STACK_GUARD_EN is defined.
module tb_ctl_stack_unit;
    localparam logic [2:0] NOP = 3'd0, ALLEN = 3'd1, POPEN = 3'd2, PUSHEN = 3'd3,
                           JUMPF = 3'd4, CALL = 3'd5, RET = 3'd6, RSVD = 3'd7;

    logic        clk = 1'b0;
    logic        reset, op_valid, cond, err_clr;
    logic [2:0]  op;
    logic [15:0] call_addr;
    logic        op_ready, en, take, err;
    logic [15:0] ret_addr;
    logic [2:0]  call_cnt;
    logic [4:0]  en_cnt;
    logic [1:0]  err_code;

    int n_run  = 0;
    int n_fail = 0;

    ctl_stack_unit #(.ADDR_W(16), .CALL_DEPTH(4), .EN_DEPTH(32)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .cond(cond),
        .call_addr(call_addr), .err_clr(err_clr), .op_ready(op_ready), .en(en),
        .take(take), .ret_addr(ret_addr), .call_cnt(call_cnt), .en_cnt(en_cnt),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic c, input logic [15:0] a);
        op_valid  = 1'b1;
        op        = o;
        cond      = c;
        call_addr = a;
        @(posedge clk);
        #1;
        op_valid  = 1'b0;
        op        = NOP;
        cond      = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; op_valid = 1'b0; op = NOP; cond = 1'b0; call_addr = '0; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_en",       32'(en), 1);
        check("rst_call_cnt", 32'(call_cnt), 0);
        check("rst_en_cnt",   32'(en_cnt), 0);
        check("rst_take",     32'(take), 0);
        check("rst_ret_addr", 32'(ret_addr), 0);
        check("rst_err",      32'(err), 0);
        check("rst_err_code", 32'(err_code), 0);
        check("rst_op_ready", 32'(op_ready), 1);
        reset = 1'b0;

        // CALL/CALL/RET/RET round trip
        issue(CALL, 1'b0, 16'h0123);
        check("c1_take", 32'(take), 1);
        check("c1_cnt",  32'(call_cnt), 1);
        issue(CALL, 1'b0, 16'h0456);
        check("c2_take", 32'(take), 1);
        check("c2_cnt",  32'(call_cnt), 2);
        issue(RET, 1'b0, 16'h0000);
        check("r1_take", 32'(take), 1);
        check("r1_addr", 32'(ret_addr), 32'h0456);
        check("r1_cnt",  32'(call_cnt), 1);
        issue(RET, 1'b0, 16'h0000);
        check("r2_take", 32'(take), 1);
        check("r2_addr", 32'(ret_addr), 32'h0123);
        check("r2_cnt",  32'(call_cnt), 0);
        idle();
        check("idle_take", 32'(take), 0);
        check("hold_addr", 32'(ret_addr), 32'h0123);

        // op_valid low: nothing accepted
        op = CALL; call_addr = 16'h0999;
        idle();
        op = NOP;
        check("novalid_cnt",  32'(call_cnt), 0);
        check("novalid_take", 32'(take), 0);

        // predication: PUSHEN, JUMPF cond=0, masked CALL and RET, POPEN
        issue(PUSHEN, 1'b0, 16'h0000);
        check("push_en_cnt", 32'(en_cnt), 1);
        check("push_take",   32'(take), 0);
        check("push_en",     32'(en), 1);
        issue(JUMPF, 1'b0, 16'h0000);
        check("jf0_take", 32'(take), 1);
        check("jf0_en",   32'(en), 0);
        issue(CALL, 1'b0, 16'h0777);
        check("mcall_take", 32'(take), 0);
        check("mcall_cnt",  32'(call_cnt), 0);
        issue(RET, 1'b0, 16'h0000);
        check("mret_take", 32'(take), 0);
        check("mret_addr", 32'(ret_addr), 32'h0123);
        issue(JUMPF, 1'b1, 16'h0000);
        check("jf_dis_take", 32'(take), 1);
        check("jf_dis_en",   32'(en), 0);
        issue(POPEN, 1'b0, 16'h0000);
        check("pop_en",     32'(en), 1);
        check("pop_en_cnt", 32'(en_cnt), 0);
        issue(JUMPF, 1'b1, 16'h0000);
        check("jf1_take", 32'(take), 0);
        check("jf1_en",   32'(en), 1);
        issue(JUMPF, 1'b0, 16'h0000);
        issue(ALLEN, 1'b0, 16'h0000);
        check("allen_en",   32'(en), 1);
        check("allen_take", 32'(take), 0);
        issue(NOP, 1'b0, 16'h0000);
        check("nop_take", 32'(take), 0);
        check("nop_cnt",  32'(call_cnt), 0);

`ifdef CTL_STACK_GUARD_EN
        // five CALLs: the fifth overflows
        for (int i = 1; i <= 4; i++) issue(CALL, 1'b0, 16'(i));
        check("g_cnt4", 32'(call_cnt), 4);
        issue(CALL, 1'b0, 16'h0005);
        check("g_ovf_err",   32'(err), 1);
        check("g_ovf_code",  32'(err_code), 1);
        check("g_ovf_cnt",   32'(call_cnt), 4);
        check("g_ovf_ready", 32'(op_ready), 0);
        check("g_ovf_take",  32'(take), 0);
        err_clr = 1'b1; idle(); err_clr = 1'b0;
        check("g_clr_ready", 32'(op_ready), 1);
        check("g_clr_err",   32'(err), 0);
        for (int i = 4; i >= 1; i--) begin
            issue(RET, 1'b0, 16'h0000);
            check("g_lifo_addr", 32'(ret_addr), 32'(i));
            check("g_lifo_take", 32'(take), 1);
        end
        check("g_cnt0", 32'(call_cnt), 0);
        issue(POPEN, 1'b0, 16'h0000);
        check("g_unf_code",  32'(err_code), 2);
        check("g_unf_encnt", 32'(en_cnt), 0);
        err_clr = 1'b1; op_valid = 1'b1; op = CALL; call_addr = 16'h0abc;
        idle();
        err_clr = 1'b0; op_valid = 1'b0; op = NOP;
        check("g_both_ready", 32'(op_ready), 1);
        check("g_both_code",  32'(err_code), 0);
        check("g_both_cnt",   32'(call_cnt), 0);
        check("g_both_take",  32'(take), 0);
        issue(RSVD, 1'b0, 16'h0000);
        check("g_ill_code", 32'(err_code), 3);
        check("g_ill_err",  32'(err), 1);
        err_clr = 1'b1; idle(); err_clr = 1'b0;
        check("g_ill_clr", 32'(err_code), 0);
`else
        // unguarded wrap: five CALLs keep the newest four
        for (int i = 1; i <= 5; i++) begin
            issue(CALL, 1'b0, 16'(i));
            check("w_err", 32'(err), 0);
        end
        check("w_cnt_sat", 32'(call_cnt), 4);
        for (int i = 5; i >= 2; i--) begin
            issue(RET, 1'b0, 16'h0000);
            check("w_ret_addr", 32'(ret_addr), 32'(i));
            check("w_ret_err",  32'(err), 0);
        end
        check("w_cnt0", 32'(call_cnt), 0);
        issue(RET, 1'b0, 16'h0000);
        check("w_ret0_addr", 32'(ret_addr), 0);
        check("w_ret0_cnt",  32'(call_cnt), 0);
        issue(POPEN, 1'b0, 16'h0000);
        check("w_pop0_en",  32'(en), 1);
        check("w_pop0_cnt", 32'(en_cnt), 0);
        for (int i = 0; i < 32; i++) issue(PUSHEN, 1'b0, 16'h0000);
        check("w_push_sat", 32'(en_cnt), 31);
        for (int i = 0; i < 31; i++) issue(POPEN, 1'b0, 16'h0000);
        check("w_pop_back", 32'(en_cnt), 0);
        check("w_pop_en",   32'(en), 1);
        issue(RSVD, 1'b0, 16'h0000);
        check("w_rsvd_err",  32'(err_code), 0);
        check("w_rsvd_take", 32'(take), 0);
        check("w_ready",     32'(op_ready), 1);
`endif

        // asynchronous reset right after an accepted RET
        do_reset();
        issue(PUSHEN, 1'b0, 16'h0000);
        issue(CALL, 1'b0, 16'h0abc);
        issue(RET, 1'b0, 16'h0000);
        check("ar_take_pre", 32'(take), 1);
        reset = 1'b1;
        #1;
        check("ar_take",   32'(take), 0);
        check("ar_cnt",    32'(call_cnt), 0);
        check("ar_en",     32'(en), 1);
        check("ar_en_cnt", 32'(en_cnt), 0);
        check("ar_addr",   32'(ret_addr), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // reset asserted while a RET is presented aborts it
        issue(CALL, 1'b0, 16'h0055);
        op_valid = 1'b1; op = RET;
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0; op = NOP;
        check("abort_take", 32'(take), 0);
        check("abort_cnt",  32'(call_cnt), 0);
        check("abort_en",   32'(en), 1);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
